csr_access_unit: RTL and testbench

//  Sequencer between execute stage and csr_file; executes Zicsr instructions (CSRRW/S/C and immediate forms).

---
 rtl/csr_access_unit_pkg.sv | 35 +++
 rtl/csr_access_unit_if.sv | 40 ++++
 rtl/csr_access_unit.sv | 123 ++++++++++++
 tb/tb_csr_access_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_access_unit_pkg.sv
// Shared types and helpers for the Zicsr access sequencer: funct3 encodings,
// FSM states and CSR address field decoding.
package csr_access_unit_pkg;

    localparam int XLEN = 32;

    typedef logic [11:0] csr_addr_t;
    typedef logic [1:0]  priv_t;

    typedef enum logic [2:0] {
        OP_RW  = 3'b001,
        OP_RS  = 3'b010,
        OP_RC  = 3'b011,
        OP_RWI = 3'b101,
        OP_RSI = 3'b110,
        OP_RCI = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_t;

    // Address bits [11:10] == 2'b11 mark the read-only CSR space.
    function automatic logic is_read_only(csr_addr_t addr);
        return addr[11:10] == 2'b11;
    endfunction

    function automatic priv_t min_priv(csr_addr_t addr);
        return addr[9:8];
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Execute-stage request/response handshake plus the csr_file read/write port.
// The slave view belongs to csr_access_unit; the master view to its environment.
interface csr_access_unit_if;
    import csr_access_unit_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    csr_addr_t             req_address;
    logic [XLEN-1:0]       req_operand;
    logic [4:0]            req_uimm;
    logic                  req_rs1_zero;
    priv_t                 priv;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [XLEN-1:0]       resp_data;
    logic                  resp_illegal;

    csr_addr_t             csr_read_address;
    logic [XLEN-1:0]       csr_read_data;
    csr_addr_t             csr_write_address;
    logic [XLEN-1:0]       csr_write_data;
    logic                  csr_write_enable;

    modport slave (
        input  req_valid, req_op, req_address, req_operand, req_uimm, req_rs1_zero, priv,
        input  resp_ready, csr_read_data,
        output req_ready, resp_valid, resp_data, resp_illegal,
        output csr_read_address, csr_write_address, csr_write_data, csr_write_enable
    );

    modport master (
        output req_valid, req_op, req_address, req_operand, req_uimm, req_rs1_zero, priv,
        output resp_ready, csr_read_data,
        input  req_ready, resp_valid, resp_data, resp_illegal,
        input  csr_read_address, csr_write_address, csr_write_data, csr_write_enable
    );

endinterface

// File: rtl/csr_access_unit.sv
// Zicsr sequencer: accepts one CSR instruction, reads the old value, checks
// legality, issues at most one csr_file write and returns the old value.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter bit CHECK_PRIV  = 1'b1,
    parameter bit ZERO_ON_ILL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    csr_access_unit_if.slave bus
);

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    csr_addr_t       addr_q, addr_d;
    priv_t           priv_q, priv_d;
    logic [XLEN-1:0] src_q, src_d;
    logic            wr_q, wr_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [XLEN-1:0] new_q, new_d;
    logic            ill_q, ill_d;

    logic [XLEN-1:0] src_in;
    logic            wr_in;
    logic [XLEN-1:0] alu_new;
    logic            illegal_op;
    logic            illegal;

    always_comb begin
        src_in = bus.req_op[2] ? {27'b0, bus.req_uimm} : bus.req_operand;
        // Set/clear forms only write when their source names a nonzero value.
        case (bus.req_op)
            OP_RW, OP_RWI:   wr_in = 1'b1;
            OP_RSI, OP_RCI:  wr_in = (bus.req_uimm != 5'd0);
            default:         wr_in = !bus.req_rs1_zero;
        endcase

        alu_new    = src_q;
        illegal_op = 1'b0;
        case (op_q)
            OP_RW, OP_RWI:   alu_new = src_q;
            OP_RS, OP_RSI:   alu_new = bus.csr_read_data | src_q;
            OP_RC, OP_RCI:   alu_new = bus.csr_read_data & ~src_q;
            default:         illegal_op = 1'b1;
        endcase

        illegal = illegal_op
                | (wr_q && is_read_only(addr_q))
                | (CHECK_PRIV && (min_priv(addr_q) > priv_q));
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        priv_d  = priv_q;
        src_d   = src_q;
        wr_d    = wr_q;
        old_d   = old_q;
        new_d   = new_q;
        ill_d   = ill_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    addr_d  = bus.req_address;
                    priv_d  = bus.priv;
                    src_d   = src_in;
                    wr_d    = wr_in;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                old_d   = bus.csr_read_data;
                new_d   = alu_new;
                ill_d   = illegal;
                state_d = (wr_q && !illegal) ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            priv_q  <= '0;
            src_q   <= '0;
            wr_q    <= 1'b0;
            old_q   <= '0;
            new_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            priv_q  <= priv_d;
            src_q   <= src_d;
            wr_q    <= wr_d;
            old_q   <= old_d;
            new_q   <= new_d;
            ill_q   <= ill_d;
        end
    end

    // Outputs decode straight from registered state so nothing glitches on inputs.
    assign bus.req_ready         = (state_q == ST_IDLE) && !rst;
    assign bus.resp_valid        = (state_q == ST_RESP);
    assign bus.resp_data         = (ZERO_ON_ILL && ill_q) ? '0 : old_q;
    assign bus.resp_illegal      = ill_q;
    assign bus.csr_read_address  = addr_q;
    assign bus.csr_write_address = addr_q;
    assign bus.csr_write_data    = new_q;
    assign bus.csr_write_enable  = (state_q == ST_WRITE);

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: two instances (privilege check + zeroing on / off)
// driven by directed and random Zicsr requests against a behavioural model.
module tb_csr_access_unit;

    localparam bit [1:0] CP = 2'b01;  // CHECK_PRIV per instance
    localparam bit [1:0] ZI = 2'b01;  // ZERO_ON_ILL per instance
    localparam logic [11:0] POOL [7] = '{12'h340, 12'h300, 12'hF14, 12'h100,
                                         12'hC00, 12'h7C0, 12'h001};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_access_unit_if if0 ();
    csr_access_unit_if if1 ();

    csr_access_unit #(.CHECK_PRIV(1'b1), .ZERO_ON_ILL(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    csr_access_unit #(.CHECK_PRIV(1'b0), .ZERO_ON_ILL(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic [1:0]  vld = 2'b00, rrdy = 2'b00;
    logic [2:0]  op_r = 3'd0;
    logic [11:0] addr_r = 12'd0;
    logic [31:0] opnd_r = 32'd0;
    logic [4:0]  ui_r = 5'd0;
    logic        rz_r = 1'b0;
    logic [1:0]  priv_r = 2'd0;

    assign if0.req_valid = vld[0];   assign if1.req_valid = vld[1];
    assign if0.resp_ready = rrdy[0]; assign if1.resp_ready = rrdy[1];
    assign if0.req_op = op_r;        assign if1.req_op = op_r;
    assign if0.req_address = addr_r; assign if1.req_address = addr_r;
    assign if0.req_operand = opnd_r; assign if1.req_operand = opnd_r;
    assign if0.req_uimm = ui_r;      assign if1.req_uimm = ui_r;
    assign if0.req_rs1_zero = rz_r;  assign if1.req_rs1_zero = rz_r;
    assign if0.priv = priv_r;        assign if1.priv = priv_r;

    logic [1:0]        rdy, rv, ill, we;
    logic [1:0][31:0]  rdata, wdata;
    logic [1:0][11:0]  waddr;
    assign rdy   = {if1.req_ready, if0.req_ready};
    assign rv    = {if1.resp_valid, if0.resp_valid};
    assign ill   = {if1.resp_illegal, if0.resp_illegal};
    assign we    = {if1.csr_write_enable, if0.csr_write_enable};
    assign rdata[0] = if0.resp_data;        assign rdata[1] = if1.resp_data;
    assign wdata[0] = if0.csr_write_data;   assign wdata[1] = if1.csr_write_data;
    assign waddr[0] = if0.csr_write_address; assign waddr[1] = if1.csr_write_address;

    // csr_file stand-ins: combinational read, write on the clock, plus a preset port.
    logic [31:0] mem [2][4096];
    logic        pre_en = 1'b0;
    int          pre_i = 0;
    logic [11:0] pre_a = 12'd0;
    logic [31:0] pre_v = 32'd0;
    assign if0.csr_read_data = mem[0][if0.csr_read_address];
    assign if1.csr_read_data = mem[1][if1.csr_read_address];
    always @(posedge clk) begin
        if (pre_en) mem[pre_i][pre_a] <= pre_v;
        if (if0.csr_write_enable) mem[0][if0.csr_write_address] <= if0.csr_write_data;
        if (if1.csr_write_enable) mem[1][if1.csr_write_address] <= if1.csr_write_data;
    end

    logic [31:0] ref_mem [2][4096];
    int passes = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic preset(input int i, input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        pre_en = 1'b1; pre_i = i; pre_a = a; pre_v = v;
        ref_mem[i][a] = v;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // One instruction on instance i; starts and ends on a falling edge.
    task automatic txn(input int i, input logic [2:0] op, input logic [11:0] a,
                       input logic [31:0] opnd, input logic [4:0] ui, input logic rz,
                       input logic [1:0] pv, input int hold, input string tag);
        logic [31:0] old, src, nv, exp_d, wd;
        logic [11:0] wa;
        logic        wr, illg, exp_w, reserved;
        int          wcnt, wcyc, rcyc, budget, lat;

        old      = ref_mem[i][a];
        src      = op[2] ? {27'd0, ui} : opnd;
        reserved = (op[1:0] == 2'b00);
        wr       = (op[1:0] == 2'b01) || (op[2] ? (ui != 5'd0) : !rz);
        nv       = (op[1:0] == 2'b01) ? src : (op[1:0] == 2'b10) ? (old | src) : (old & ~src);
        illg     = reserved || (wr && a[11:10] == 2'b11) || (CP[i] && (a[9:8] > pv));
        exp_w    = wr && !illg;
        exp_d    = (illg && ZI[i]) ? 32'd0 : old;
        lat      = exp_w ? 3 : 2;

        budget = 0;
        while (rdy[i] !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check({tag, ":req_ready_idle"}, rdy[i], 1);

        op_r = op; addr_r = a; opnd_r = opnd; ui_r = ui; rz_r = rz; priv_r = pv;
        vld[i] = 1'b1;
        @(posedge clk);
        #1;
        vld[i] = 1'b0;
        // Scramble request fields: they must be ignored once the unit is busy.
        op_r = 3'($urandom); addr_r = 12'($urandom); opnd_r = $urandom;
        ui_r = 5'($urandom); rz_r = 1'($urandom); priv_r = 2'($urandom);

        wcnt = 0; wcyc = 0; rcyc = 0; wa = 12'd0; wd = 32'd0;
        for (int k = 1; k <= 8 && rcyc == 0; k++) begin
            @(negedge clk);
            if (we[i]) begin wcnt++; wcyc = k; wa = waddr[i]; wd = wdata[i]; end
            if (rv[i]) rcyc = k;
        end
        check({tag, ":write_count"}, wcnt, exp_w ? 1 : 0);
        if (exp_w) begin
            check({tag, ":write_cycle"}, wcyc, 2);
            check({tag, ":write_addr"}, wa, a);
            check({tag, ":write_data"}, wd, nv);
        end
        check({tag, ":resp_latency"}, rcyc, lat);
        check({tag, ":resp_data"}, rdata[i], exp_d);
        check({tag, ":resp_illegal"}, ill[i], illg);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, ":hold_valid"}, rv[i], 1);
            check({tag, ":hold_data"}, rdata[i], exp_d);
            check({tag, ":hold_illegal"}, ill[i], illg);
            check({tag, ":hold_req_ready"}, rdy[i], 0);
            check({tag, ":hold_no_write"}, we[i], 0);
        end
        rrdy[i] = 1'b1;
        @(posedge clk);
        #1;
        rrdy[i] = 1'b0;
        @(negedge clk);
        check({tag, ":ready_after_hs"}, rdy[i], 1);
        check({tag, ":valid_dropped"}, rv[i], 0);
        if (exp_w) ref_mem[i][a] = nv;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [11:0] ra;
        logic [1:0]  rp;
        logic [4:0]  rui;

        #2;
        @(negedge clk);
        check("reset:req_ready", rdy[0], 0);
        check("reset:resp_valid", rv[0], 0);
        check("reset:write_enable", we[0], 0);
        check("reset:resp_data", rdata[0], 0);
        check("reset:resp_illegal", ill[0], 0);
        check("reset:resp_valid1", rv[1], 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset:req_ready_release", rdy, 2'b11);

        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 7; p++) preset(i, POOL[p], 32'd0);
        preset(0, 12'h300, 32'h8);
        preset(1, 12'h300, 32'h8);
        preset(0, 12'hF14, 32'h1234_5678);
        preset(1, 12'hF14, 32'h1234_5678);

        // Directed scenarios.
        txn(0, 3'b001, 12'h340, 32'hDEAD_BEEF, 5'd0, 1'b0, 2'd3, 0, "rw_340");
        txn(0, 3'b010, 12'h300, 32'h0000_0080, 5'd0, 1'b0, 2'd3, 0, "rs_300");
        txn(0, 3'b011, 12'h300, 32'h0000_0008, 5'd0, 1'b0, 2'd3, 0, "rc_300");
        txn(0, 3'b110, 12'hF14, 32'h0,         5'd0, 1'b0, 2'd3, 0, "rsi_ro_nowr");
        txn(0, 3'b001, 12'hF14, 32'hFFFF_FFFF, 5'd0, 1'b0, 2'd3, 0, "rw_ro_ill");
        txn(1, 3'b001, 12'hF14, 32'hFFFF_FFFF, 5'd0, 1'b0, 2'd3, 0, "rw_ro_ill_keep");
        txn(0, 3'b010, 12'h300, 32'h0000_0100, 5'd0, 1'b0, 2'd0, 0, "priv_u_ill");
        txn(1, 3'b010, 12'h300, 32'h0000_0100, 5'd0, 1'b0, 2'd0, 0, "priv_u_nocheck");
        txn(0, 3'b010, 12'h300, 32'h0,         5'd0, 1'b0, 2'd3, 5, "hold5");
        txn(0, 3'b100, 12'h340, 32'h1,         5'd3, 1'b0, 2'd3, 0, "reserved_op");
        txn(0, 3'b011, 12'h340, 32'hFFFF_FFFF, 5'd0, 1'b1, 2'd3, 0, "rc_x0_nowr");

        // Reset while the unit sits in READ of a CSRRW.
        op_r = 3'b001; addr_r = 12'h340; opnd_r = 32'h5A5A_5A5A; priv_r = 2'd3; rz_r = 1'b0;
        vld[0] = 1'b1;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst:resp_valid", rv[0], 0);
        check("midrst:write_enable", we[0], 0);
        check("midrst:req_ready_in_rst", rdy[0], 0);
        @(negedge clk);
        check("midrst:write_enable2", we[0], 0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst:no_write_after", we[0], 0);
            check("midrst:no_resp_after", rv[0], 0);
        end
        check("midrst:req_ready", rdy[0], 1);
        check("midrst:csr_untouched", mem[0][12'h340], ref_mem[0][12'h340]);

        // Random instruction mix over a small address pool.
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = POOL[$urandom_range(0, 6)];
            rp  = 2'($urandom_range(0, 2));
            if (rp == 2'd2) rp = 2'd3;
            rui = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            txn(n % 2, rop, ra, $urandom, rui, ($urandom_range(0, 3) == 0),
                rp, $urandom_range(0, 2), $sformatf("rand%0d", n));
        end

        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 7; p++)
                check($sformatf("final_mem%0d_%03h", i, POOL[p]), mem[i][POOL[p]], ref_mem[i][POOL[p]]);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
